// File: rtl/cnn_mem_lane_reader_if.sv
// cnn_mem_lane_reader_if
//   Bundles the RAM Avalon read port and the 16-bit lane stream of the
//   lane reader.
//   master : the lane reader (drives RAM address/strobe and the stream).
//   slave  : the environment (RAM returns read data, sink drives st_ready).
//   Signals:
//     mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken
//     mem_readdata  RAM data, valid the cycle after a chipselect cycle
//     st_data, st_valid, st_last  lane stream toward the MAC datapath
//     st_ready      downstream accept
interface cnn_mem_lane_reader_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [7:0]        mem_byteenable;
  logic              mem_clken;
  logic [63:0]       mem_readdata;
  logic [15:0]       st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_last;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  mem_readdata,
    output st_data, st_valid, st_last,
    input  st_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output mem_readdata,
    input  st_data, st_valid, st_last,
    output st_ready
  );
endinterface

// File: rtl/cnn_mem_lane_reader.sv
// cnn_mem_lane_reader
//   On a start command, sweeps num_words consecutive 64-bit RAM words from
//   base_addr (address wraps modulo 2^ADDR_W), buffers each returned word in
//   a small FIFO and emits it as four 16-bit lanes, low lane first.
//   Ports:
//     clk, reset_n         clock, asynchronous active-low reset
//     start                command strobe, only sampled in IDLE
//     base_addr, num_words command parameters, latched on an accepted start
//     busy                 high while a command is being fetched/drained
//     done                 one-cycle pulse at the end of a command
//     bus (master)         RAM read port and lane stream
module cnn_mem_lane_reader #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       num_words,
  output logic                  busy,
  output logic                  done,
  cnn_mem_lane_reader_if.master bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W:0]   issue_left;   // reads not yet issued
  logic [ADDR_W:0]   pop_left;     // words not yet fully emitted
  logic [ADDR_W-1:0] addr_q;
  logic              cs_q;
  logic              rd_pending;   // read issued last cycle, data arrives now
  logic              done_q;

  logic [63:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [1:0]        lane_idx;

  logic [63:0]       head;
  logic [15:0]       lane;
  logic              valid;
  logic              last;
  logic              hs;
  logic              push;
  logic              pop;
  logic [CW:0]       occ;
  logic              room;
  logic              issue_ok;

  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 8'hFF;
  assign bus.mem_clken      = 1'b1;
  assign bus.mem_address    = addr_q;
  assign bus.mem_chipselect = cs_q;

  assign busy = (state == S_FETCH) || (state == S_DRAIN);
  assign done = done_q;

  assign head  = fifo_mem[rd_ptr];
  assign valid = (count != '0);
  assign hs    = valid && bus.st_ready;
  assign push  = rd_pending;
  assign pop   = hs && (lane_idx == 2'd3);
  assign last  = valid && (lane_idx == 2'd3) && (pop_left == (ADDR_W+1)'(1));

  always_comb begin
    lane = '0;
    case (lane_idx)
      2'd0:    lane = head[15:0];
      2'd1:    lane = head[31:16];
      2'd2:    lane = head[47:32];
      default: lane = head[63:48];
    endcase
  end

  // Data is gated so an empty FIFO presents zero rather than stale storage.
  assign bus.st_data  = valid ? lane : '0;
  assign bus.st_valid = valid;
  assign bus.st_last  = last;

  // Words buffered, in the RAM pipeline, and being issued this cycle all
  // reserve a FIFO slot, so a returning word always has room.
  assign occ      = (CW+1)'(count) + (CW+1)'(rd_pending) + (CW+1)'(cs_q);
  assign room     = occ < (CW+1)'(FIFO_DEPTH);
  assign issue_ok = (state == S_FETCH) && (issue_left != '0) && room;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      issue_left <= '0;
      pop_left   <= '0;
      addr_q     <= '0;
      cs_q       <= 1'b0;
      rd_pending <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      lane_idx   <= '0;
    end else begin
      done_q     <= 1'b0;
      cs_q       <= 1'b0;
      rd_pending <= cs_q;

      case (state)
        S_IDLE: begin
          if (start) begin
            pop_left <= num_words;
            if (num_words == '0) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              // First read goes out directly from IDLE to meet the two-cycle
              // start-to-first-lane latency.
              cs_q       <= 1'b1;
              addr_q     <= base_addr;
              issue_left <= num_words - (ADDR_W+1)'(1);
              state      <= (num_words == (ADDR_W+1)'(1)) ? S_DRAIN : S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (issue_ok) begin
            cs_q       <= 1'b1;
            addr_q     <= addr_q + ADDR_W'(1);
            issue_left <= issue_left - (ADDR_W+1)'(1);
            if (issue_left == (ADDR_W+1)'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (hs && last) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (hs) lane_idx <= lane_idx + 2'd1;
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        pop_left <= pop_left - (ADDR_W+1)'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: contents are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_readdata;
  end

endmodule

// File: tb/tb_cnn_mem_lane_reader.sv
module tb_cnn_mem_lane_reader;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_words;
  logic              busy;
  logic              done;

  cnn_mem_lane_reader_if #(.ADDR_W(ADDR_W)) bus ();

  cnn_mem_lane_reader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency
  logic [63:0] ram [4096];
  always @(posedge clk)
    if (bus.mem_chipselect) bus.mem_readdata <= ram[bus.mem_address];

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0]       exp_q [$];   // {last, data}
  logic [ADDR_W-1:0] addr_exp [$];

  int ready_mode = 0;
  bit zl_expect = 0;
  bit done_exp_next = 0;
  bit no_bubble = 0;
  bit seen_first = 0;
  int hs_count = 0;
  int done_count = 0;
  int issued = 0, consumed = 0, lane_cnt = 0, max_occ = 0;
  bit prev_v = 0, prev_r = 0, prev_l = 0;
  logic [15:0] prev_d = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  logic [16:0] mon_e;
  logic        mon_dexp;
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mem_chipselect) begin
        issued++;
        chk("cs_while_busy", busy, 1);
        if (addr_exp.size() == 0) chk("unexpected_chipselect", 1, 0);
        else chk("mem_address", bus.mem_address, addr_exp.pop_front());
      end
      if (issued - consumed > max_occ) max_occ = issued - consumed;

      if (prev_v && !prev_r) begin
        chk("stall_valid", bus.st_valid, 1);
        chk("stall_data", bus.st_data, prev_d);
        chk("stall_last", bus.st_last, prev_l);
      end

      if (no_bubble && seen_first && exp_q.size() != 0)
        chk("no_bubble", bus.st_valid, 1);

      mon_dexp = done_exp_next || zl_expect;
      if (done || mon_dexp) chk("done_pulse", done, mon_dexp);
      if (done) done_count++;
      done_exp_next = 0;
      zl_expect = 0;

      if (bus.st_valid && bus.st_ready) begin
        seen_first = 1;
        hs_count++;
        if (exp_q.size() == 0) chk("unexpected_lane", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("st_data", bus.st_data, mon_e[15:0]);
          chk("st_last", bus.st_last, mon_e[16]);
          if (mon_e[16]) done_exp_next = 1;
        end
        lane_cnt++;
        if (lane_cnt == 4) begin
          consumed++;
          lane_cnt = 0;
        end
      end
      prev_v = bus.st_valid;
      prev_r = bus.st_ready;
      prev_d = bus.st_data;
      prev_l = bus.st_last;
    end
  end

  // Ready driver
  initial begin
    bus.st_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.st_ready = (ready_mode != 0) ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  task automatic push_words(input logic [ADDR_W-1:0] b, input int n);
    logic [ADDR_W-1:0] a;
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      a = b + ADDR_W'(i);
      w = ram[a];
      addr_exp.push_back(a);
      for (int k = 0; k < 4; k++)
        exp_q.push_back({(i == n - 1) && (k == 3), w[16*k +: 16]});
    end
  endtask

  task automatic start_cmd(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
    start = 1'b1;
    base_addr = b;
    num_words = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = 12'hABC;
    num_words = 13'd7;
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int d0;
    d0 = done_count;
    for (int i = 0; i < maxc && done_count == d0; i++) begin
      @(posedge clk);
      #1;
    end
    chk({nm, "_done_seen"}, done_count - d0, 1);
    chk({nm, "_lanes_left"}, exp_q.size(), 0);
    chk({nm, "_reads_left"}, addr_exp.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_mem_address"}, bus.mem_address, 0);
    chk({nm, "_chipselect"}, bus.mem_chipselect, 0);
    chk({nm, "_st_data"}, bus.st_data, 0);
    chk({nm, "_st_valid"}, bus.st_valid, 0);
    chk({nm, "_st_last"}, bus.st_last, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, d0;
    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    num_words = '0;
    for (int a = 0; a < 4096; a++)
      for (int k = 0; k < 4; k++)
        ram[a][16*k +: 16] = {2'(k), 2'b10, 12'(a)};
    ram[12'h010] = 64'h0004_0003_0002_0001;
    ram[12'h011] = 64'h0008_0007_0006_0005;
    for (int i = 0; i < 64; i++)
      ram[12'h400 + i] = {16'(4*i+3), 16'(4*i+2), 16'(4*i+1), 16'(4*i)};

    #2;
    chk_reset_outputs("reset");
    chk("tie_mem_write", bus.mem_write, 0);
    chk("tie_byteenable", bus.mem_byteenable, 8'hFF);
    chk("tie_clken", bus.mem_clken, 1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic stream, explicit expected lanes
    no_bubble = 1; seen_first = 0;
    addr_exp.push_back(12'h010);
    addr_exp.push_back(12'h011);
    for (int v = 1; v <= 8; v++) exp_q.push_back({v == 8, 16'(v)});
    start_cmd(12'h010, 13'd2);
    @(negedge clk);
    chk("basic_busy", busy, 1);
    chk("basic_lat_c0", bus.st_valid, 0);
    @(negedge clk);
    chk("basic_lat_c1", bus.st_valid, 0);
    @(negedge clk);
    chk("basic_lat_c2", bus.st_valid, 1);
    chk("basic_first_lane", bus.st_data, 16'h0001);
    wait_done("basic", 100);

    // Backpressure, 64 words of incrementing lanes
    no_bubble = 0; max_occ = 0;
    for (int i = 0; i < 64; i++) begin
      addr_exp.push_back(12'h400 + 12'(i));
      for (int k = 0; k < 4; k++) exp_q.push_back({(i == 63) && (k == 3), 16'(4*i+k)});
    end
    ready_mode = 1;
    start_cmd(12'h400, 13'd64);
    wait_done("backpressure", 3000);
    ready_mode = 0;
    chk("max_occupancy_le_4", max_occ <= DEPTH, 1);
    @(posedge clk);
    #1;

    // Address wrap
    no_bubble = 1; seen_first = 0;
    push_words(12'hFFE, 4);
    start_cmd(12'hFFE, 13'd4);
    wait_done("wrap", 200);

    // Zero length
    start_cmd(12'h123, 13'd0);
    zl_expect = 1;
    wait_done("zero_len", 20);

    // Start while busy is ignored
    seen_first = 0;
    push_words(12'h100, 8);
    start_cmd(12'h100, 13'd8);
    repeat (6) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 12'h200; num_words = 13'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignored_start", 300);

    // Reset mid-stream
    no_bubble = 0;
    push_words(12'h500, 16);
    h0 = hs_count;
    start_cmd(12'h500, 13'd16);
    for (int i = 0; i < 200 && hs_count - h0 < 5; i++) begin
      @(posedge clk);
      #1;
    end
    chk("reset_mid_5_lanes", hs_count - h0, 5);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    addr_exp.delete();
    issued = 0; consumed = 0; lane_cnt = 0;
    done_exp_next = 0; prev_v = 0;
    d0 = done_count;
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_no_done", done_count - d0, 0);
    no_bubble = 1; seen_first = 0;
    push_words(12'h300, 3);
    start_cmd(12'h300, 13'd3);
    wait_done("after_reset", 200);

    // Full sweep
    seen_first = 0;
    d0 = done_count;
    push_words(12'h000, 4096);
    start_cmd(12'h000, 13'd4096);
    wait_done("full_sweep", 20000);
    repeat (4) @(posedge clk);
    #1;
    chk("full_sweep_done_once", done_count - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cnn_mem_lane_reader.md
# cnn_mem_lane_reader

Read-side streaming stage for the 64-bit on-chip feature/weight RAM (4096 words, 12-bit word address, single port, one-cycle read latency). On a start command it sweeps a contiguous word range, reads each 64-bit word through the RAM's Avalon slave port, and unpacks it into four 16-bit fixed-point lanes. The lanes are emitted on a valid/ready stream toward the CNN MAC datapath. A small word FIFO absorbs the fixed read latency and downstream backpressure.

## Interface
- ADDR_W, 12, RAM word-address width
- FIFO_DEPTH, 4, words buffered (power of 2, ≥2)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; latched on start
- num_words  in  ADDR_W+1  word count 0..4096; latched on start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of command
- mem_address  out  ADDR_W  RAM word address (registered)
- mem_chipselect  out  1  read strobe (registered)
- mem_write  out  1  tied 0
- mem_byteenable  out  8  tied 8'hFF
- mem_clken  out  1  tied 1
- mem_readdata  in  64  RAM read data, valid the cycle after a chipselect cycle
- st_data  out  16  output lane
- st_valid  out  1  lane valid
- st_ready  in  1  downstream accept
- st_last  out  1  high with the final lane of the command

## Operation
- Reset values: busy=0, done=0, mem_address=0, mem_chipselect=0, st_data=0, st_valid=0, st_last=0; FIFO empty; state IDLE.
- States and transitions:
  - IDLE: on start=1, latch base_addr and num_words.
    - num_words=0 → DONE.
    - Otherwise → FETCH.
  - FETCH: issue reads. After the final issue → DRAIN.
  - DRAIN: no issues. When the final lane handshakes → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Issue rule: a read is registered for the next cycle only when both hold:
  - words remain;
  - fifo_count + inflight + issuing < FIFO_DEPTH.
  - With this rule the FIFO never overflows. A returning word is always accepted.
- Address arithmetic: mem_address increments by 1 per issue, modulo 2^ADDR_W. Wrap-around from 4095 to 0 is legal.
- Capture: mem_readdata is written to the FIFO on the clock edge that ends the cycle following each chipselect cycle. Exactly one capture per issue.
- Unpack order:
  - lane 0 = bits [15:0], emitted first;
  - lane 1 = bits [31:16];
  - lane 2 = bits [47:32];
  - lane 3 = bits [63:48].
  - The FIFO head pops after the lane 3 handshake.
- Stream rules:
  - A handshake occurs when st_valid && st_ready.
  - While st_valid=1 && st_ready=0, st_data and st_last hold stable.
  - st_valid never depends combinationally on st_ready.
- st_last is high only on lane 3 of word num_words-1.
- start while busy=1 is ignored; latched parameters are unaffected.
- Reset mid-command: all state clears immediately. An in-flight read return is discarded. No done pulse is generated.

## Timing
- Start accepted at edge E0:
  - mem_chipselect=1 with mem_address=base_addr in cycle E0–E1;
  - data captured at E2;
  - st_valid=1 from E2, so the first lane is visible 2 cycles after E0.
- With st_ready held high, lanes stream one per cycle with no bubbles. Bubbles are permitted only before the first lane.
- done is asserted in the cycle after the final lane handshake. busy falls with the done pulse.
- A num_words=0 command produces done in the cycle after E0, with no chipselect.
- Sustained read issue rate is at most 1 word per 4 cycles under full throughput. mem_chipselect is never asserted in IDLE or DONE.

## Test plan
- Basic stream:
  - Stimulus: RAM[0x010]=64'h0004_0003_0002_0001, RAM[0x011]=64'h0008_0007_0006_0005; start with base=0x010, num_words=2; st_ready=1.
  - Required: st_data 1..8 on consecutive cycles, first lane 2 cycles after start; st_last only with 8; done one cycle later; exactly 2 chipselect cycles.
- Backpressure:
  - Stimulus: num_words=64, incrementing lane pattern; st_ready random with 30% low.
  - Required: exact in-order lane sequence, no loss or duplicate; data stable while stalled; FIFO count never exceeds 4.
- Wrap:
  - Stimulus: base=0xFFE, num_words=4.
  - Required: mem_address sequence 0xFFE, 0xFFF, 0x000, 0x001; 16 lanes correct.
- Zero length and ignored start:
  - Stimulus: num_words=0; then start pulsed mid-command with a different base.
  - Required: zero length gives done next cycle and no chipselect; the mid-command start causes no change to the address sequence or lane count.
- Reset mid-stream:
  - Stimulus: reset_n low for 1 cycle after 5 lanes of a 16-word command.
  - Required: all outputs return to reset values asynchronously; no done; a fresh start then streams correctly from its new base.
- Full sweep:
  - Stimulus: num_words=4096, st_ready=1.
  - Required: 16384 lanes; st_last on the last lane only; done once.
